// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, funct3 codes, AXI size encodings and helper
//               functions for the parametrised load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_D = 3'd2,
        WR   = 3'd3,
        WR_B = 3'd4,
        RESP = 3'd5
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_BUS      = 2'b10
    } lsu_err_e;

    // RISC-V load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // AXI AxSIZE encodings
    localparam logic [2:0] AXSIZE_1B = 3'd0;
    localparam logic [2:0] AXSIZE_2B = 3'd1;
    localparam logic [2:0] AXSIZE_4B = 3'd2;
    localparam logic [2:0] AXSIZE_8B = 3'd3;

    // Illegal encodings are folded into the misaligned class so they never
    // reach the bus.
    function automatic logic lsu_misaligned(input logic [2:0] f3,
                                            input logic [2:0] addr_lo,
                                            input logic       is64);
        logic bad;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo[1:0] != 2'b00);
            F3_WU:       bad = !is64 || (addr_lo[1:0] != 2'b00);
            F3_D:        bad = !is64 || (addr_lo != 3'b000);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Access size encoding depends only on the low two funct3 bits
    function automatic logic [2:0] lsu_axsize(input logic [2:0] f3);
        logic [2:0] sz;
        case (f3[1:0])
            2'b00:   sz = AXSIZE_1B;
            2'b01:   sz = AXSIZE_2B;
            2'b10:   sz = AXSIZE_4B;
            default: sz = AXSIZE_8B;
        endcase
        return sz;
    endfunction

    // Byte-enable pattern for an offset-zero access of the given size
    function automatic logic [7:0] lsu_size_mask(input logic [2:0] f3);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load-lane select and sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [2:0]        i_func3,
    input  logic [OFF_W-1:0]  i_offset,
    output logic [DATA_W-1:0] o_result
);

    logic [DATA_W-1:0] w_lane;
    logic [63:0]       w_lane64;
    logic [63:0]       w_res64;
    logic              w_sext;

    // Bring the addressed byte lane down to bit 0; work in 64 bits so the
    // extension widths are the same for both bus widths.
    assign w_lane   = i_data >> {i_offset, 3'b000};
    assign w_lane64 = 64'(w_lane);
    assign w_sext   = !i_func3[2];

    // Extend the selected lane according to access size and signedness
    always_comb begin
        w_res64 = w_lane64;
        case (i_func3[1:0])
            2'b00:   w_res64 = {{56{w_sext & w_lane64[7]}},  w_lane64[7:0]};
            2'b01:   w_res64 = {{48{w_sext & w_lane64[15]}}, w_lane64[15:0]};
            2'b10:   w_res64 = {{32{w_sext & w_lane64[31]}}, w_lane64[31:0]};
            default: w_res64 = w_lane64;
        endcase
    end

    assign o_result = DATA_W'(w_res64);

endmodule
`default_nettype wire

// File: rtl/lsu_axi_gen.sv
`default_nettype none
// ============================================================================
// Module      : lsu_axi_gen
// Description : Parametrised AXI-Lite load/store unit (EXU -> WBU). One
//               request per handshake, one bus beat with real size/strobes,
//               misalignment trapped before any bus traffic.
//               Optional macro LSU_PERF_EN adds 32-bit performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_axi_gen
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_func3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
`ifdef LSU_PERF_EN
    ,
    output logic [31:0]         perf_loads,
    output logic [31:0]         perf_stores,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_errs
`endif
);

    localparam int   OFF_W  = $clog2(DATA_W/8);
    localparam int   STRB_W = DATA_W/8;
    localparam logic IS_64  = (DATA_W == 64);

    lsu_state_e          r_state_q,     w_state_d;
    logic [ADDR_W-1:0]   r_addr_q,      w_addr_d;
    logic [2:0]          r_func3_q,     w_func3_d;
    logic                r_we_q,        w_we_d;
    logic [DATA_W-1:0]   r_wdata_q,     w_wdata_d;
    logic                r_aw_pend_q,   w_aw_pend_d;
    logic                r_w_pend_q,    w_w_pend_d;
    logic [DATA_W-1:0]   r_rsp_rdata_q, w_rsp_rdata_d;
    lsu_err_e            r_rsp_err_q,   w_rsp_err_d;
    logic [DATA_W-1:0]   w_load_data;
    logic [OFF_W-1:0]    w_offset;

    assign w_offset = r_addr_q[OFF_W-1:0];

    lsu_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .i_data   (rdata),
        .i_func3  (r_func3_q),
        .i_offset (w_offset),
        .o_result (w_load_data)
    );

    // Next-state and request/response capture
    always_comb begin
        w_state_d     = r_state_q;
        w_addr_d      = r_addr_q;
        w_func3_d     = r_func3_q;
        w_we_d        = r_we_q;
        w_wdata_d     = r_wdata_q;
        w_aw_pend_d   = r_aw_pend_q;
        w_w_pend_d    = r_w_pend_q;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_err_d   = r_rsp_err_q;
        case (r_state_q)
            IDLE: begin
                if (req_valid) begin
                    w_addr_d  = req_addr;
                    w_func3_d = req_func3;
                    w_we_d    = req_we;
                    w_wdata_d = req_wdata;
                    if (lsu_misaligned(req_func3, req_addr[2:0], IS_64)) begin
                        w_state_d     = RESP;
                        w_rsp_err_d   = ERR_MISALIGN;
                        w_rsp_rdata_d = '0;
                    end else if (req_we) begin
                        w_state_d   = WR;
                        w_aw_pend_d = 1'b1;
                        w_w_pend_d  = 1'b1;
                    end else begin
                        w_state_d = RD_A;
                    end
                end
            end
            RD_A: begin
                if (arready) w_state_d = RD_A == RD_A ? RD_D : RD_D;
            end
            RD_D: begin
                if (rvalid) begin
                    w_state_d = RESP;
                    if (rresp inside {2'b10, 2'b11}) begin
                        w_rsp_err_d   = ERR_BUS;
                        w_rsp_rdata_d = '0;
                    end else begin
                        w_rsp_err_d   = ERR_OK;
                        // stores never return data
                        w_rsp_rdata_d = r_we_q ? '0 : w_load_data;
                    end
                end
            end
            WR: begin
                if (awready) w_aw_pend_d = 1'b0;
                if (wready)  w_w_pend_d  = 1'b0;
                if (!w_aw_pend_d && !w_w_pend_d) w_state_d = WR_B;
            end
            WR_B: begin
                if (bvalid) begin
                    w_state_d     = RESP;
                    w_rsp_rdata_d = '0;
                    w_rsp_err_d   = (bresp inside {2'b10, 2'b11}) ? ERR_BUS : ERR_OK;
                end
            end
            RESP: begin
                if (rsp_ready) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_addr_q      <= '0;
            r_func3_q     <= '0;
            r_we_q        <= 1'b0;
            r_wdata_q     <= '0;
            r_aw_pend_q   <= 1'b0;
            r_w_pend_q    <= 1'b0;
            r_rsp_rdata_q <= '0;
            r_rsp_err_q   <= ERR_OK;
        end else begin
            r_state_q     <= w_state_d;
            r_addr_q      <= w_addr_d;
            r_func3_q     <= w_func3_d;
            r_we_q        <= w_we_d;
            r_wdata_q     <= w_wdata_d;
            r_aw_pend_q   <= w_aw_pend_d;
            r_w_pend_q    <= w_w_pend_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

    assign req_ready = (r_state_q == IDLE);
    assign rsp_valid = (r_state_q == RESP);
    assign rsp_rdata = r_rsp_rdata_q;
    assign rsp_err   = r_rsp_err_q;

    // Both address channels point at the bus-aligned word containing the access
    assign araddr  = {r_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign arsize  = lsu_axsize(r_func3_q);
    assign arvalid = (r_state_q == RD_A);
    assign rready  = (r_state_q == RD_D);

    assign awaddr  = {r_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign awsize  = lsu_axsize(r_func3_q);
    assign awvalid = (r_state_q == WR) && r_aw_pend_q;
    assign wvalid  = (r_state_q == WR) && r_w_pend_q;
    assign wdata   = r_wdata_q << {w_offset, 3'b000};
    assign wstrb   = STRB_W'(lsu_size_mask(r_func3_q)) << w_offset;
    assign bready  = (r_state_q == WR_B);

`ifdef LSU_PERF_EN
    logic [31:0] r_perf_loads_q,  w_perf_loads_d;
    logic [31:0] r_perf_stores_q, w_perf_stores_d;
    logic [31:0] r_perf_stall_q,  w_perf_stall_d;
    logic [31:0] r_perf_errs_q,   w_perf_errs_d;
    logic        w_rsp_hs;

    assign w_rsp_hs = (r_state_q == RESP) && rsp_ready;

    // Counter updates: completions on the response handshake, stalls per bus cycle
    always_comb begin
        w_perf_loads_d  = r_perf_loads_q;
        w_perf_stores_d = r_perf_stores_q;
        w_perf_stall_d  = r_perf_stall_q;
        w_perf_errs_d   = r_perf_errs_q;
        if (w_rsp_hs) begin
            if (r_we_q) w_perf_stores_d = r_perf_stores_q + 32'd1;
            else        w_perf_loads_d  = r_perf_loads_q + 32'd1;
            if (r_rsp_err_q != ERR_OK) w_perf_errs_d = r_perf_errs_q + 32'd1;
        end
        if (r_state_q inside {RD_A, RD_D, WR, WR_B}) w_perf_stall_d = r_perf_stall_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_loads_q  <= '0;
            r_perf_stores_q <= '0;
            r_perf_stall_q  <= '0;
            r_perf_errs_q   <= '0;
        end else begin
            r_perf_loads_q  <= w_perf_loads_d;
            r_perf_stores_q <= w_perf_stores_d;
            r_perf_stall_q  <= w_perf_stall_d;
            r_perf_errs_q   <= w_perf_errs_d;
        end
    end

    assign perf_loads        = r_perf_loads_q;
    assign perf_stores       = r_perf_stores_q;
    assign perf_stall_cycles = r_perf_stall_q;
    assign perf_errs         = r_perf_errs_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_axi_gen
// Description : Directed self-checking bench for lsu_axi_gen; one 32-bit and
//               one 64-bit instance share stimulus, sel64 picks the active one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_axi_gen;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, sel64 = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_func3 = '0;
    logic [31:0] req_addr = '0;
    logic [63:0] req_wdata = '0, rdata = '0;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [1:0]  rresp = '0, bresp = '0;

    logic        rq32, rv32, arv32, rr32, awv32, wv32, br32;
    logic [31:0] rd32, ara32, awa32, wd32;
    logic [1:0]  re32;
    logic [2:0]  ars32, aws32;
    logic [3:0]  ws32;
    logic        rq64, rv64, arv64, rr64, awv64, wv64, br64;
    logic [63:0] rd64, wd64;
    logic [31:0] ara64, awa64;
    logic [1:0]  re64;
    logic [2:0]  ars64, aws64;
    logic [7:0]  ws64;

`ifdef LSU_PERF_EN
    logic [31:0] pl32, ps32, pst32, pe32, pl64, ps64, pst64, pe64;
`endif

    lsu_axi_gen #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel64), .req_ready(rq32), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .rsp_valid(rv32), .rsp_ready(rsp_ready), .rsp_rdata(rd32), .rsp_err(re32),
        .araddr(ara32), .arsize(ars32), .arvalid(arv32), .arready(arready),
        .rdata(rdata[31:0]), .rresp(rresp), .rvalid(rvalid), .rready(rr32),
        .awaddr(awa32), .awsize(aws32), .awvalid(awv32), .awready(awready),
        .wdata(wd32), .wstrb(ws32), .wvalid(wv32), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(br32)
`ifdef LSU_PERF_EN
        , .perf_loads(pl32), .perf_stores(ps32), .perf_stall_cycles(pst32), .perf_errs(pe32)
`endif
    );

    lsu_axi_gen #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel64), .req_ready(rq64), .req_we(req_we),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv64), .rsp_ready(rsp_ready), .rsp_rdata(rd64), .rsp_err(re64),
        .araddr(ara64), .arsize(ars64), .arvalid(arv64), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rr64),
        .awaddr(awa64), .awsize(aws64), .awvalid(awv64), .awready(awready),
        .wdata(wd64), .wstrb(ws64), .wvalid(wv64), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(br64)
`ifdef LSU_PERF_EN
        , .perf_loads(pl64), .perf_stores(ps64), .perf_stall_cycles(pst64), .perf_errs(pe64)
`endif
    );

    // Observed outputs of whichever instance is selected
    logic        o_req_ready, o_rsp_valid, o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready;
    logic [63:0] o_rsp_rdata, o_wdata;
    logic [31:0] o_araddr, o_awaddr;
    logic [1:0]  o_rsp_err;
    logic [2:0]  o_arsize, o_awsize;
    logic [7:0]  o_wstrb;
    assign o_req_ready = sel64 ? rq64  : rq32;
    assign o_rsp_valid = sel64 ? rv64  : rv32;
    assign o_arvalid   = sel64 ? arv64 : arv32;
    assign o_rready    = sel64 ? rr64  : rr32;
    assign o_awvalid   = sel64 ? awv64 : awv32;
    assign o_wvalid    = sel64 ? wv64  : wv32;
    assign o_bready    = sel64 ? br64  : br32;
    assign o_rsp_rdata = sel64 ? rd64  : {32'h0, rd32};
    assign o_wdata     = sel64 ? wd64  : {32'h0, wd32};
    assign o_araddr    = sel64 ? ara64 : ara32;
    assign o_awaddr    = sel64 ? awa64 : awa32;
    assign o_rsp_err   = sel64 ? re64  : re32;
    assign o_arsize    = sel64 ? ars64 : ars32;
    assign o_awsize    = sel64 ? aws64 : aws32;
    assign o_wstrb     = sel64 ? ws64  : {4'h0, ws32};

    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sel64 = s[0];
            #1;
            vectors++;
            if ({o_arvalid, o_awvalid, o_wvalid, o_rsp_valid, o_rready, o_bready, o_req_ready} !== 7'b0000001) begin
                miscompares++;
                $display("FAIL reset_ctrl%0d: got %b want 0000001", s, {o_arvalid, o_awvalid, o_wvalid, o_rsp_valid, o_rready, o_bready, o_req_ready});
            end
            vectors++;
            if ({o_rsp_err, o_rsp_rdata} !== 66'h0) begin
                miscompares++;
                $display("FAIL reset_rsp%0d: got err=%b data=%h want 0/0", s, o_rsp_err, o_rsp_rdata);
            end
        end
        sel64 = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    // Load against a zero-wait slave; hold keeps rsp_ready low that many cycles
    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [63:0] rd, input logic [1:0] rr,
                           input logic [63:0] exp_d, input logic [1:0] exp_e, input int exp_lat,
                           input logic [31:0] exp_aa, input logic [2:0] exp_as, input int hold);
        int cyc, ar_cnt, aw_cnt;
        logic [31:0] got_aa;
        logic [2:0]  got_as;
        cyc = 0; ar_cnt = 0; aw_cnt = 0; got_aa = '0; got_as = '0;
        req_we = 1'b0; req_func3 = f3; req_addr = addr; req_wdata = 64'hA5A5_5A5A_A5A5_5A5A;
        rdata = rd; rresp = rr; arready = 1'b1; rvalid = 1'b1; req_valid = 1'b1;
        vectors++;
        if (o_req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s req_ready: got %b want 1", name, o_req_ready);
        end
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (o_rsp_valid !== 1'b1 && cyc < 20) begin
            if (o_arvalid === 1'b1) begin ar_cnt++; got_aa = o_araddr; got_as = o_arsize; end
            if (o_awvalid === 1'b1 || o_wvalid === 1'b1) aw_cnt++;
            tick();
            cyc++;
        end
        vectors++;
        if (cyc !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        vectors++;
        if (ar_cnt !== ((exp_e == ERR_MISALIGN) ? 1 : 1) - ((exp_e == ERR_MISALIGN) ? 1 : 0) || aw_cnt !== 0) begin
            miscompares++;
            $display("FAIL %s bus_activity: got ar=%0d aw=%0d want ar=%0d aw=0", name, ar_cnt, aw_cnt, (exp_e == ERR_MISALIGN) ? 0 : 1);
        end
        if (exp_e != ERR_MISALIGN) begin
            vectors++;
            if (got_aa !== exp_aa || got_as !== exp_as) begin
                miscompares++;
                $display("FAIL %s ar: got addr=%h size=%0d want addr=%h size=%0d", name, got_aa, got_as, exp_aa, exp_as);
            end
        end
        vectors++;
        if (o_rsp_rdata !== exp_d || o_rsp_err !== exp_e) begin
            miscompares++;
            $display("FAIL %s rsp: got data=%h err=%b want data=%h err=%b", name, o_rsp_rdata, o_rsp_err, exp_d, exp_e);
        end
        for (int i = 0; i < hold; i++) begin
            rdata = ~rd;
            rvalid = i[0];
            tick();
            vectors++;
            if ({o_rsp_valid, o_req_ready, o_rsp_err, o_rsp_rdata} !== {1'b1, 1'b0, exp_e, exp_d}) begin
                miscompares++;
                $display("FAIL %s hold%0d: got v=%b rdy=%b err=%b data=%h want v=1 rdy=0 err=%b data=%h",
                         name, i, o_rsp_valid, o_req_ready, o_rsp_err, o_rsp_rdata, exp_e, exp_d);
            end
        end
        rvalid = 1'b0;
        rsp_ready = 1'b1;
        vectors++;
        if ({o_rsp_valid, o_req_ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL %s consume_cycle: got v/rdy=%b want 10", name, {o_rsp_valid, o_req_ready});
        end
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s after_consume: got v/rdy=%b want 01", name, {o_rsp_valid, o_req_ready});
        end
    endtask

    // Store with wready always high; awready rises at cycle aw_rdy_cyc after accept
    task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [63:0] wd, input int aw_rdy_cyc, input logic [1:0] br,
                            input logic [63:0] exp_wd, input logic [7:0] exp_strb,
                            input logic [31:0] exp_aa, input logic [2:0] exp_as,
                            input logic [1:0] exp_e, input int exp_lat, input int exp_aw_cnt);
        int cyc, ar_cnt, aw_cnt, w_cnt;
        logic [63:0] got_wd;
        logic [7:0]  got_strb;
        logic [31:0] got_aa;
        logic [2:0]  got_as;
        cyc = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        got_wd = '0; got_strb = '0; got_aa = '0; got_as = '0;
        req_we = 1'b1; req_func3 = f3; req_addr = addr; req_wdata = wd;
        arready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = br; awready = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (o_rsp_valid !== 1'b1 && cyc < 20) begin
            awready = (cyc >= aw_rdy_cyc);
            if (o_wvalid === 1'b1)  begin w_cnt++;  got_wd = o_wdata; got_strb = o_wstrb; end
            if (o_awvalid === 1'b1) begin aw_cnt++; got_aa = o_awaddr; got_as = o_awsize; end
            if (o_arvalid === 1'b1) ar_cnt++;
            tick();
            cyc++;
        end
        awready = 1'b0;
        bvalid = 1'b0;
        vectors++;
        if (cyc !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        vectors++;
        if (ar_cnt !== 0 || aw_cnt !== exp_aw_cnt || w_cnt !== ((exp_aw_cnt == 0) ? 0 : 1)) begin
            miscompares++;
            $display("FAIL %s bus_activity: got ar=%0d aw=%0d w=%0d want ar=0 aw=%0d w=%0d",
                     name, ar_cnt, aw_cnt, w_cnt, exp_aw_cnt, (exp_aw_cnt == 0) ? 0 : 1);
        end
        if (exp_aw_cnt != 0) begin
            vectors++;
            if (got_wd !== exp_wd || got_strb !== exp_strb || got_aa !== exp_aa || got_as !== exp_as) begin
                miscompares++;
                $display("FAIL %s beat: got wdata=%h strb=%h awaddr=%h size=%0d want wdata=%h strb=%h awaddr=%h size=%0d",
                         name, got_wd, got_strb, got_aa, got_as, exp_wd, exp_strb, exp_aa, exp_as);
            end
        end
        vectors++;
        if (o_rsp_rdata !== 64'h0 || o_rsp_err !== exp_e) begin
            miscompares++;
            $display("FAIL %s rsp: got data=%h err=%b want data=0 err=%b", name, o_rsp_rdata, o_rsp_err, exp_e);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        vectors++;
        if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s single_rsp: got v/rdy=%b want 01", name, {o_rsp_valid, o_req_ready});
        end
    endtask

    task automatic test_loads32();
        do_load("lw",  F3_W,  32'h8000_0004, 64'hDEAD_BEEF, 2'b00, 64'hDEAD_BEEF, 2'b00, 3, 32'h8000_0004, 3'd2, 0);
        do_load("lb",  F3_B,  32'h8000_0003, 64'h80FF_FFFF, 2'b00, 64'hFFFF_FF80, 2'b00, 3, 32'h8000_0000, 3'd0, 0);
        do_load("lbu", F3_BU, 32'h8000_0003, 64'h80FF_FFFF, 2'b00, 64'h0000_0080, 2'b00, 3, 32'h8000_0000, 3'd0, 0);
        do_load("lh",  F3_H,  32'h8000_0002, 64'h8001_0000, 2'b00, 64'hFFFF_8001, 2'b00, 3, 32'h8000_0000, 3'd1, 0);
        do_load("lhu", F3_HU, 32'h8000_0002, 64'h8001_0000, 2'b00, 64'h0000_8001, 2'b00, 3, 32'h8000_0000, 3'd1, 0);
    endtask

    task automatic test_stores32();
        do_store("sh_awdelay", F3_H, 32'h8000_0002, 64'h0000_1234, 3, 2'b00,
                 64'h1234_0000, 8'h0C, 32'h8000_0000, 3'd1, 2'b00, 5, 3);
        do_store("sw", F3_W, 32'h8000_0008, 64'hCAFE_F00D, 1, 2'b00,
                 64'hCAFE_F00D, 8'h0F, 32'h8000_0008, 3'd2, 2'b00, 3, 1);
        do_store("sb", F3_B, 32'h8000_0001, 64'h0000_00AB, 1, 2'b00,
                 64'h0000_AB00, 8'h02, 32'h8000_0000, 3'd0, 2'b00, 3, 1);
    endtask

    task automatic test_misaligned();
        do_load("lw_mis",   F3_W, 32'h8000_0002, 64'h1111_1111, 2'b00, 64'h0, 2'b01, 1, 32'h0, 3'd0, 0);
        do_load("f3_111",   3'b111, 32'h8000_0000, 64'h1111_1111, 2'b00, 64'h0, 2'b01, 1, 32'h0, 3'd0, 0);
        do_load("ld_on_32", F3_D, 32'h8000_0000, 64'h1111_1111, 2'b00, 64'h0, 2'b01, 1, 32'h0, 3'd0, 0);
        do_store("sh_mis",  F3_H, 32'h8000_0001, 64'h0000_1234, 1, 2'b00,
                 64'h0, 8'h00, 32'h0, 3'd0, 2'b01, 1, 0);
    endtask

    task automatic test_bus_err();
        do_load("lw_slverr", F3_W, 32'h8000_0010, 64'h1234_5678, 2'b10, 64'h0, 2'b10, 3, 32'h8000_0010, 3'd2, 4);
        do_store("sw_decerr", F3_W, 32'h8000_000C, 64'h5555_AAAA, 1, 2'b11,
                 64'h5555_AAAA, 8'h0F, 32'h8000_000C, 3'd2, 2'b10, 3, 1);
    endtask

    // Requests held back to back: each consumed response costs one idle cycle
    task automatic test_back_to_back();
        logic [1:0] exp_pat [0:4];
        exp_pat[0] = 2'b01; exp_pat[1] = 2'b10; exp_pat[2] = 2'b01; exp_pat[3] = 2'b10; exp_pat[4] = 2'b01;
        req_we = 1'b0; req_func3 = F3_W; req_addr = 32'h8000_0002;
        req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin req_valid = 1'b0; rsp_ready = 1'b0; end
            vectors++;
            if ({o_rsp_valid, o_req_ready} !== exp_pat[i]) begin
                miscompares++;
                $display("FAIL b2b cycle%0d: got v/rdy=%b want %b", i, {o_rsp_valid, o_req_ready}, exp_pat[i]);
            end
            if (i < 4) tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        req_we = 1'b0; req_func3 = F3_W; req_addr = 32'h8000_0020;
        arready = 1'b1; rvalid = 1'b0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        vectors++;
        if ({o_rready, o_arvalid} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_mid in_rd_d: got rready/arvalid=%b want 10", {o_rready, o_arvalid});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({o_arvalid, o_awvalid, o_wvalid, o_rsp_valid, o_rready, o_bready, o_req_ready} !== 7'b0000001) begin
            miscompares++;
            $display("FAIL rst_mid abandon: got %b want 0000001", {o_arvalid, o_awvalid, o_wvalid, o_rsp_valid, o_rready, o_bready, o_req_ready});
        end
        rvalid = 1'b1; rdata = 64'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_rsp_valid === 1'b1) seen++;
        end
        rvalid = 1'b0;
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_mid no_completion: got %0d rsp cycles want 0", seen);
        end
    endtask

    task automatic test_dw64();
        sel64 = 1'b1;
        #1;
        do_store("sd", F3_D, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 1, 2'b00,
                 64'h0123_4567_89AB_CDEF, 8'hFF, 32'h0000_0008, 3'd3, 2'b00, 3, 1);
        do_store("sw64_hi", F3_W, 32'h0000_0004, 64'h0000_0000_1122_3344, 1, 2'b00,
                 64'h1122_3344_0000_0000, 8'hF0, 32'h0000_0000, 3'd2, 2'b00, 3, 1);
        do_load("ld",  F3_D,  32'h0000_0010, 64'hFEDC_BA98_7654_3210, 2'b00,
                64'hFEDC_BA98_7654_3210, 2'b00, 3, 32'h0000_0010, 3'd3, 0);
        do_load("lw64",  F3_W,  32'h0000_0004, 64'h8000_0001_0000_0000, 2'b00,
                64'hFFFF_FFFF_8000_0001, 2'b00, 3, 32'h0000_0000, 3'd2, 0);
        do_load("lwu64", F3_WU, 32'h0000_0004, 64'h8000_0001_0000_0000, 2'b00,
                64'h0000_0000_8000_0001, 2'b00, 3, 32'h0000_0000, 3'd2, 0);
        do_load("ld_mis", F3_D, 32'h0000_0004, 64'h1, 2'b00, 64'h0, 2'b01, 1, 32'h0, 3'd0, 0);
        sel64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_loads32();
        test_stores32();
        test_misaligned();
        test_bus_err();
        test_back_to_back();
        test_reset_mid();
        test_dw64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
